// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: walks an LSTM stack slot by slot (slot = layer*NUM_DIRECTIONS + dir).
// For each slot it loads that slot's weight, bias and scale base addresses, pulses layer_rdy
// to the layer engine, waits for layer_done, and pulses lstm_done after the last slot.
// Optional feature: define LSTM_SEQ_TIMEOUT_EN to add a per-slot RUN timeout
// (input timeout_limit, sticky output err_timeout).
module lstm_seq_ctrl #(
    parameter int unsigned NUM_LAYERS     = 2,
    parameter int unsigned NUM_DIRECTIONS = 2,
    parameter int unsigned SRAM8192_AW    = 13,
    parameter int unsigned SRAM1024_AW    = 10,
    parameter int unsigned TO_W           = 16,
    localparam int unsigned NS     = NUM_LAYERS * NUM_DIRECTIONS,
    localparam int unsigned SLOT_W = (NS > 1) ? $clog2(NS) : 1,
    localparam int unsigned LW     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int unsigned DW     = (NUM_DIRECTIONS > 1) ? $clog2(NUM_DIRECTIONS) : 1
) (
    input  logic                      wclk,
    input  logic                      rst_n,
    input  logic                      lstm_rdy,
    input  logic                      abort,
    input  logic                      layer_done,
    input  logic [NS*SRAM8192_AW-1:0] addr_w_init_all,
    input  logic [NS*SRAM8192_AW-1:0] addr_u_init_all,
    input  logic [NS*SRAM1024_AW-1:0] addr_b_init_all,
    input  logic [NS*SRAM1024_AW-1:0] addr_scales_init_all,
`ifdef LSTM_SEQ_TIMEOUT_EN
    input  logic [TO_W-1:0]           timeout_limit,
    output logic                      err_timeout,
`endif
    output logic [SRAM8192_AW-1:0]    addr_lstm_w_init,
    output logic [SRAM8192_AW-1:0]    addr_lstm_u_init,
    output logic [SRAM1024_AW-1:0]    addr_lstm_b_init,
    output logic [SRAM1024_AW-1:0]    addr_lstm_scales_init,
    output logic                      layer_rdy,
    output logic [LW-1:0]             layer_idx,
    output logic [DW-1:0]             dir_idx,
    output logic [1:0]                lstm_top_state,
    output logic                      busy,
    output logic                      lstm_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NS - 1);

    logic [1:0]             state_q, state_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [SRAM8192_AW-1:0] w_q, w_d, u_q, u_d;
    logic [SRAM1024_AW-1:0] b_q, b_d, s_q, s_d;
    logic                   layer_rdy_q, layer_rdy_d;
    logic                   lstm_done_q, lstm_done_d;
    logic                   busy_q, busy_d;
    logic [LW-1:0]          layer_idx_q, layer_idx_d;
    logic [DW-1:0]          dir_idx_q, dir_idx_d;

    logic [SRAM8192_AW-1:0] sel_w, sel_u;
    logic [SRAM1024_AW-1:0] sel_b, sel_s;

`ifdef LSTM_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W1 = TO_W + 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic            to_hit;

    // A slot times out on its timeout_limit-th RUN cycle if layer_done has not arrived
    always_comb begin
        to_hit = (timeout_limit != '0)
              && ((TO_W1'(to_cnt_q) + TO_W1'(1)) >= TO_W1'(timeout_limit));
    end
`else
    // TO_W only sizes the optional timeout counter
    if (TO_W == 0) begin : g_to_w_unused
    end
`endif

    // Sequencer next state: slot advance, abort and (optional) timeout handling
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
`ifdef LSTM_SEQ_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (lstm_rdy && !abort) begin
                    state_d = ST_LOAD;
                    slot_d  = '0;
`ifdef LSTM_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
`ifdef LSTM_SEQ_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            ST_RUN: begin
`ifdef LSTM_SEQ_TIMEOUT_EN
                to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                if (layer_done) begin
                    if (slot_q == SLOT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                        slot_d  = slot_q + SLOT_W'(1);
                    end
                end
`ifdef LSTM_SEQ_TIMEOUT_EN
                else if (to_hit && !abort) begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                    err_d   = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase
        // Abort wins over everything else once a sequence is in flight
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            slot_d  = '0;
        end
    end

    // Decode the next slot into its base addresses and layer/direction indices
    always_comb begin
        sel_w       = '0;
        sel_u       = '0;
        sel_b       = '0;
        sel_s       = '0;
        layer_idx_d = '0;
        dir_idx_d   = '0;
        for (int unsigned l = 0; l < NUM_LAYERS; l++) begin
            for (int unsigned d = 0; d < NUM_DIRECTIONS; d++) begin
                if (slot_d == SLOT_W'(l * NUM_DIRECTIONS + d)) begin
                    sel_w       = addr_w_init_all[(l*NUM_DIRECTIONS+d)*SRAM8192_AW +: SRAM8192_AW];
                    sel_u       = addr_u_init_all[(l*NUM_DIRECTIONS+d)*SRAM8192_AW +: SRAM8192_AW];
                    sel_b       = addr_b_init_all[(l*NUM_DIRECTIONS+d)*SRAM1024_AW +: SRAM1024_AW];
                    sel_s       = addr_scales_init_all[(l*NUM_DIRECTIONS+d)*SRAM1024_AW +: SRAM1024_AW];
                    layer_idx_d = LW'(l);
                    dir_idx_d   = DW'(d);
                end
            end
        end
    end

    // Output next values; addresses follow slot 0 in IDLE, latch on LOAD, hold otherwise
    always_comb begin
        w_d         = w_q;
        u_d         = u_q;
        b_d         = b_q;
        s_d         = s_q;
        layer_rdy_d = (state_q == ST_LOAD) && (state_d == ST_RUN);
        lstm_done_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        if ((state_d == ST_IDLE) || (state_d == ST_LOAD)) begin
            w_d = sel_w;
            u_d = sel_u;
            b_d = sel_b;
            s_d = sel_s;
        end
    end

    // State and output registers
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            w_q         <= '0;
            u_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            layer_rdy_q <= 1'b0;
            lstm_done_q <= 1'b0;
            busy_q      <= 1'b0;
            layer_idx_q <= '0;
            dir_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            w_q         <= w_d;
            u_q         <= u_d;
            b_q         <= b_d;
            s_q         <= s_d;
            layer_rdy_q <= layer_rdy_d;
            lstm_done_q <= lstm_done_d;
            busy_q      <= busy_d;
            layer_idx_q <= layer_idx_d;
            dir_idx_q   <= dir_idx_d;
        end
    end

`ifdef LSTM_SEQ_TIMEOUT_EN
    // Timeout counter and sticky error flag
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timeout = err_q;
`endif

    assign addr_lstm_w_init      = w_q;
    assign addr_lstm_u_init      = u_q;
    assign addr_lstm_b_init      = b_q;
    assign addr_lstm_scales_init = s_q;
    assign layer_rdy             = layer_rdy_q;
    assign lstm_done             = lstm_done_q;
    assign busy                  = busy_q;
    assign layer_idx             = layer_idx_q;
    assign dir_idx               = dir_idx_q;
    assign lstm_top_state        = state_q;

endmodule
